// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, port ids
// and a width helper for small counters.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      WAIT_RD = 1'b1
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   // Bits needed to hold 0..maxVal, never less than one.
   function automatic int unsigned cntWidth(input int unsigned maxVal);
      return (maxVal < 2) ? 32'd1 : 32'($clog2(maxVal + 1));
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and Memoria64.
// The master side is the environment (requesters plus memory), the slave side is the arbiter.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 64,
   parameter int unsigned DW = 64
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt;
   logic          dbg_rvalid;

   logic [DW-1:0] rdata;
   logic          busy;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid,
      input  rdata, busy, mem_addr, mem_wdata, mem_wr
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid,
      output rdata, busy, mem_addr, mem_wdata, mem_wr
   );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_counter #(
   parameter int unsigned MAX = 8,
   parameter int unsigned W   = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != W'(MAX))) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single, non-pipelined data-memory port: CPU has priority,
// the debug/loader port wins once it has been denied MAX_WAIT consecutive cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned AW       = 64,
   parameter int unsigned DW       = 64
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   localparam int unsigned LW = cntWidth(RD_LAT - 1);
   localparam int unsigned SW = cntWidth(MAX_WAIT);

   arb_state_t    state;
   arb_state_t    stateNext;
   logic [LW-1:0] latCnt;
   logic [AW-1:0] latAddr;
   logic          owner;
   logic [SW-1:0] starveCnt;

   logic          dbgWins;
   logic          cpuWins;
   logic          grantWe;
   logic [AW-1:0] grantAddr;
   logic          rdStart;
   logic          dbgGnt;

   // Winner selection, only meaningful while IDLE.
   assign dbgWins   = bus.dbg_req && (!bus.cpu_req || (starveCnt == SW'(MAX_WAIT)));
   assign cpuWins   = bus.cpu_req && !dbgWins;
   assign grantWe   = dbgWins ? bus.dbg_we   : bus.cpu_we;
   assign grantAddr = dbgWins ? bus.dbg_addr : bus.cpu_addr;
   assign rdStart   = (state == IDLE) && (cpuWins || dbgWins) && !grantWe;
   assign dbgGnt    = (state == IDLE) && dbgWins;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic: writes complete in the grant cycle, reads wait out the latency.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (rdStart) begin
               stateNext = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (latCnt == '0) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Outstanding-read context: owner, address held on the memory port, latency countdown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latAddr <= '0;
         owner   <= PORT_CPU;
         latCnt  <= '0;
      end else if (rdStart) begin
         latAddr <= grantAddr;
         owner   <= dbgWins ? PORT_DBG : PORT_CPU;
         latCnt  <= LW'(RD_LAT - 1);
      end else if ((state == WAIT_RD) && (latCnt != '0)) begin
         latCnt  <= latCnt - LW'(1);
      end
   end

   // Output decode; everything is forced low while reset is asserted.
   always_comb begin
      bus.cpu_gnt    = 1'b0;
      bus.dbg_gnt    = 1'b0;
      bus.cpu_rvalid = 1'b0;
      bus.dbg_rvalid = 1'b0;
      bus.rdata      = DW'(0);
      bus.busy       = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = DW'(0);
      bus.mem_wr     = 1'b0;
      if (reset) begin
         case (state)
            IDLE: begin
               bus.cpu_gnt   = cpuWins;
               bus.dbg_gnt   = dbgWins;
               bus.mem_addr  = grantAddr;
               bus.mem_wdata = dbgWins ? bus.dbg_wdata : bus.cpu_wdata;
               bus.mem_wr    = (cpuWins || dbgWins) && grantWe;
            end
            WAIT_RD: begin
               bus.busy     = 1'b1;
               bus.mem_addr = latAddr;
               if (latCnt == '0) begin
                  bus.cpu_rvalid = (owner == PORT_CPU);
                  bus.dbg_rvalid = (owner == PORT_DBG);
                  bus.rdata      = bus.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   // Starvation guard: counts consecutive denied debug cycles.
   arb_sat_counter #(
      .MAX (MAX_WAIT),
      .W   (SW)
   ) uStarve (
      .clk   (clk),
      .reset (reset),
      .clr   (!bus.dbg_req || dbgGnt),
      .inc   (bus.dbg_req && !dbgGnt),
      .cnt   (starveCnt)
   );

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port (Memoria64) between two requesters: the CPU datapath (port 0, normally driven by the control unit's data-memory strobes and the ALU-output address) and a debug/loader port (port 1) used to preload or inspect data memory while the core runs. It issues one transaction at a time, because memory is not pipelined. It tracks read latency and returns read data to the owning requester with a valid strobe. A starvation guard ensures the debug port is served even under continuous CPU traffic.

## Interface
- RD_LAT, default 1: memory read latency in cycles, from address presented to `mem_rdata` valid; must be ≥1.
- MAX_WAIT, default 8: consecutive denied cycles after which a pending debug request wins over the CPU.
- AW, default 64: address width.
- DW, default 64: data width.

- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req / dbg_req  input  1  request from port 0 / port 1
- cpu_we / dbg_we  input  1  1 = write, 0 = read
- cpu_addr / dbg_addr  input  AW  address
- cpu_wdata / dbg_wdata  input  DW  write data
- cpu_gnt / dbg_gnt  output  1  request accepted at this clock edge
- cpu_rvalid / dbg_rvalid  output  1  read data valid, one-cycle pulse
- rdata  output  DW  read data, shared by both ports and qualified by the rvalid strobes
- mem_addr  output  AW  to Memoria64 raddress and waddress
- mem_wdata  output  DW  to Memoria64 Datain
- mem_wr  output  1  to Memoria64 Wr
- mem_rdata  input  DW  from Memoria64 Dataout
- busy  output  1  read outstanding

## Operation
- Reset values of all outputs are 0. State is IDLE, both counters are 0, and the latched address is 0.
- States are IDLE and WAIT_RD.
- IDLE:
  - Select a winner among the asserted requests.
  - The CPU wins unless `dbg_req` is set and `starve_cnt == MAX_WAIT`; in that case the debug port wins.
  - The winner's `*_gnt` is driven combinationally high.
  - `mem_addr` and `mem_wdata` are driven from the winner.
  - For a write, `mem_wr = 1` for that cycle and the state stays IDLE.
  - For a read, the address and owner are latched, `lat_cnt` is loaded with RD_LAT-1, and the state moves to WAIT_RD.
- WAIT_RD:
  - `mem_addr` is held at the latched address and `mem_wr = 0`.
  - No grants are issued. `lat_cnt` decrements each cycle.
  - When `lat_cnt == 0`, the owner's `rvalid = 1` and `rdata = mem_rdata`; the next state is IDLE.
- Starvation counter:
  - Increments each cycle that `dbg_req = 1` and `dbg_gnt = 0`.
  - Saturates at MAX_WAIT.
  - Clears on `dbg_gnt`, or on any cycle in which `dbg_req = 0`.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until they see `gnt` high at a clock edge. They deassert `req` (or present a new transaction) in the next cycle.
- When no grant is issued, `mem_addr` is driven from the CPU port and `mem_wr` is 0.
- An asynchronous reset in any state returns immediately to reset values. An outstanding read is dropped with no rvalid.

## Timing
- Write granted at edge T: memory is written at edge T, and a new grant is possible in cycle T+1.
- Read granted at edge T: `rvalid` is high in cycle T+RD_LAT and the next grant is possible in cycle T+RD_LAT+1.
- Back-to-back CPU reads with RD_LAT = 1 give one read every 2 cycles.
- `gnt`, `mem_addr`, `mem_wdata` and `mem_wr` are combinational from the requests and state in IDLE. The `rvalid` outputs, `rdata`, `busy` and the latched address are decoded from registered state.
- Worst-case debug wait under continuous CPU reads is MAX_WAIT grant slots.

## Structure
- Package `dmem_arb_pkg` contains:
  - `arb_state_t` enum {IDLE, WAIT_RD}
  - port-id constants `PORT_CPU = 1'b0` and `PORT_DBG = 1'b1`
- Sub-module `arb_sat_counter`: a saturating up-counter with clear and a max parameter, used for the starvation guard.
- The latency countdown stays inline.

## Test plan
- **Reset mid-read:** pulse `reset` low during WAIT_RD after a CPU read to address 16.
  - All outputs go to 0 immediately, no rvalid follows, and the next CPU request is granted in IDLE.
- **CPU write then read:** CPU write of `64'hDEAD_BEEF` to address 8, then a read of address 8.
  - `mem_wr` is high for 1 cycle and `cpu_gnt` is asserted twice.
  - `cpu_rvalid` appears RD_LAT cycles after the read grant, with `rdata = 64'hDEAD_BEEF`.
- **Simultaneous requests:** both ports request reads of addresses 0 and 254 in the same cycle with `starve_cnt = 0`.
  - CPU is granted first; debug is granted in the first IDLE cycle after `cpu_rvalid`.
  - `dbg_rvalid` returns the contents of 254.
- **Starvation:** MAX_WAIT = 8, CPU requests reads continuously, `dbg_req` held high.
  - `dbg_gnt` is asserted once `starve_cnt` reaches 8; the counter then clears and the CPU resumes.
- **Latency sweep:** RD_LAT = 3, one CPU read.
  - `busy` is high for 3 cycles, `cpu_rvalid` pulses exactly one cycle in cycle T+3, and no grant is issued in between.
- **Write to reserved vector address:** debug write of `64'h0000_0040` to address 255 while the CPU is idle.
  - `dbg_gnt` is asserted in the same cycle; a subsequent CPU read of 255 returns `64'h40`.
